conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, result word width.
REQ-002 SHALL provide parameter DRAIN_LEN, default 4, systolic flush cycles after the last issued tap.
REQ-003 SHALL provide parameter LEN_2BY2, default 18, and LEN_3BY3, default 12, compute-phase cycle counts for those modes.
REQ-004 SHALL have one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-005 Ports, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin job when idle
- mode  in  2  0 = single, 1 = 2by2, 2 = 3by3, 3 = reserved
- sys_en  out  1  datapath enable
- input_addr  out  5  input array address
- filter_addr  out  5  filter array address
- buffer_we  out  4  write enables C11, C12, C21, C22 (bit 0 = C11)
- buffer_read_addr  out  2  result buffer read address
- result_in  in  DATA_W  buffer read data, valid one cycle after the address
- result_out  out  DATA_W  captured result
- result_valid  out  1  result_out strobe
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

Function
REQ-006 The FSM SHALL have states IDLE, COMPUTE, DRAIN, READ and FINISH.
REQ-007 In IDLE, a start with mode != 3 SHALL latch mode and enter COMPUTE next cycle.
REQ-008 A start with mode == 3 SHALL be ignored.
REQ-009 Start SHALL be ignored in every state other than IDLE.
REQ-010 busy SHALL be high in every state except IDLE.
REQ-011 In COMPUTE, sys_en SHALL be 1 and the tap counter k SHALL increment from 0 each cycle.
REQ-012 Single mode SHALL take 36 COMPUTE cycles: window w = k/9 (0..3), tap t = k%9.
REQ-013 Single mode SHALL drive input_addr = base[w] + (t/3)*4 + t%3, with base = {0, 1, 4, 5}, and filter_addr = t.
REQ-014 Single mode SHALL assert buffer_we one-hot bit w only on cycles with t == 8.
REQ-015 2by2 and 3by3 modes SHALL take LEN_2BY2 or LEN_3BY3 COMPUTE cycles, with input_addr = filter_addr = k[4:0] and buffer_we = 0.
REQ-016 After the last COMPUTE cycle the FSM SHALL enter DRAIN.
REQ-017 DRAIN SHALL hold sys_en = 1 with addresses at 0 for DRAIN_LEN cycles, then enter READ.
REQ-018 READ SHALL last 4 cycles, with buffer_read_addr = 0, 1, 2, 3.
REQ-019 result_out SHALL register result_in one cycle after each read address, with result_valid high for exactly 4 consecutive cycles; the last strobe coincides with FINISH.
REQ-020 FINISH SHALL last one cycle with done = 1, then return to IDLE.
REQ-021 Outside COMPUTE and DRAIN, sys_en SHALL be 0; outside READ, buffer_read_addr SHALL be 0.
REQ-022 All outputs SHALL be registered.
REQ-023 Counters SHALL never wrap within a job; k SHALL be 6 bits wide.

Reset
REQ-024 rst SHALL force IDLE on the next clock edge, from any state including mid-job.
REQ-025 Reset values SHALL be: all outputs 0 and counters 0; a pending result_valid is cancelled.
REQ-026 If start and rst are high in the same cycle, rst SHALL win.

Configuration
REQ-027 When CONV_SEQ_ABORT_EN is defined, the block SHALL add an input port abort (1 bit, after mode).
REQ-028 With CONV_SEQ_ABORT_EN, abort high in any non-IDLE state SHALL return the FSM to IDLE next cycle with done = 0 and all outputs 0.
REQ-029 Without CONV_SEQ_ABORT_EN, the abort port SHALL not exist and jobs SHALL always complete.

Structure
REQ-030 A shared package conv_pkg SHALL hold the mode encoding constants, the state enum, and the single-mode window base table.
REQ-031 The address generator (k to input_addr/filter_addr/buffer_we) SHALL be one sub-module, conv_addr_gen; the FSM and readout SHALL stay in the top level.

Verification
REQ-032 Single mode: start with mode = 0 -> addresses 0, 1, 2, 4, 5, 6, 8, 9, 10 on cycles 1..9; buffer_we = 0001 on cycle 9, 1000 on cycle 36; done on cycle 45.
REQ-033 Readout: result_in returns 8'h11, 8'h22, 8'h33, 8'h44 -> result_out shows the same sequence on 4 consecutive result_valid cycles.
REQ-034 3by3 mode, LEN_3BY3 = 12 -> sys_en high for 16 cycles, buffer_we always 0, done 21 cycles after start.
REQ-035 rst asserted at k = 20 in single mode -> IDLE and all outputs 0 next cycle; a new start then runs a full job.
REQ-036 Start with mode = 3, and start while busy -> ignored, busy unchanged, no done.
REQ-037 With CONV_SEQ_ABORT_EN: abort in READ -> IDLE next cycle, result_valid drops, no done pulse.

Source files
------------

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution sequencer:
//   - mode encoding constants (single / 2by2 / 3by3 / reserved)
//   - sequencer state enum
//   - single-mode 3x3 window base address table (4 windows over a 4x4 input)
//   - single-mode compute length
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_2BY2   = 2'd1;
  localparam logic [1:0] MODE_3BY3   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // Four 3x3 windows, nine taps each.
  localparam logic [5:0] SINGLE_LAST_K = 6'd35;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPUTE = 3'd1,
    DRAIN   = 3'd2,
    READ    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  // Top-left element of each 3x3 window inside the row-major 4x4 input.
  localparam logic [4:0] WIN_BASE [4] = '{5'd0, 5'd1, 5'd4, 5'd5};

endpackage

// File: rtl/conv_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_addr_gen
// Combinational address generator: maps the tap counter k to array addresses
// and result-buffer write enables. The parent registers the outputs.
// Ports:
//   active       in  1  high while the sequencer is in its compute phase
//   mode         in  2  job mode (conv_pkg MODE_*)
//   k            in  6  tap counter
//   input_addr   out 5  input array address
//   filter_addr  out 5  filter array address
//   buffer_we    out 4  result buffer write enables, bit 0 = C11
// Single mode walks four 3x3 windows: window w = k/9, tap t = k%9,
// input address = base[w] + row(t)*4 + col(t), filter address = t, and the
// window's buffer write enable fires on its last tap (t == 8).
// ---------------------------------------------------------------------------
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic       active,
  input  logic [1:0] mode,
  input  logic [5:0] k,
  output logic [4:0] input_addr,
  output logic [4:0] filter_addr,
  output logic [3:0] buffer_we
);

  logic [1:0] win_s;
  logic [3:0] tap_s;
  logic [1:0] row_s;
  logic [1:0] col_s;

  // Split k into window / row / column using compares instead of dividers.
  always_comb begin
    if (k >= 6'd27) begin
      win_s = 2'd3;
    end else if (k >= 6'd18) begin
      win_s = 2'd2;
    end else if (k >= 6'd9) begin
      win_s = 2'd1;
    end else begin
      win_s = 2'd0;
    end
    // Truncation is intentional: the remainder is always below 9 in range.
    tap_s = 4'(k - (6'(win_s) * 6'd9));
    if (tap_s >= 4'd6) begin
      row_s = 2'd2;
    end else if (tap_s >= 4'd3) begin
      row_s = 2'd1;
    end else begin
      row_s = 2'd0;
    end
    col_s = 2'(tap_s - (4'(row_s) * 4'd3));
  end

  // Mode-dependent address and write-enable selection.
  always_comb begin
    input_addr  = 5'd0;
    filter_addr = 5'd0;
    buffer_we   = 4'b0000;
    if (active) begin
      case (mode)
        MODE_SINGLE: begin
          input_addr  = WIN_BASE[win_s] + {1'b0, row_s, 2'b00} + {3'b000, col_s};
          filter_addr = {1'b0, tap_s};
          if (tap_s == 4'd8) begin
            buffer_we = 4'b0001 << win_s;
          end else begin
            buffer_we = 4'b0000;
          end
        end
        MODE_2BY2, MODE_3BY3: begin
          input_addr  = k[4:0];
          filter_addr = k[4:0];
          buffer_we   = 4'b0000;
        end
        default: begin
          input_addr  = 5'd0;
          filter_addr = 5'd0;
          buffer_we   = 4'b0000;
        end
      endcase
    end else begin
      input_addr  = 5'd0;
      filter_addr = 5'd0;
      buffer_we   = 4'b0000;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// ---------------------------------------------------------------------------
// conv_sequencer
// Job sequencer for a small systolic convolution datapath. A job runs
// IDLE -> COMPUTE -> DRAIN -> READ -> FINISH -> IDLE, generating array
// addresses during COMPUTE, flushing the array during DRAIN, reading the
// four result words during READ and pulsing done in FINISH.
// Optional feature macro: CONV_SEQ_ABORT_EN adds the abort input.
// Ports:
//   clk               in  1       clock
//   rst               in  1       synchronous active-high reset
//   start             in  1       begin a job (accepted only in IDLE)
//   mode              in  2       0 single, 1 2by2, 2 3by3, 3 reserved
//   abort             in  1       (CONV_SEQ_ABORT_EN only) cancel the job
//   sys_en            out 1       datapath enable
//   input_addr        out 5       input array address
//   filter_addr       out 5       filter array address
//   buffer_we         out 4       result buffer write enables, bit 0 = C11
//   buffer_read_addr  out 2       result buffer read address
//   result_in         in  DATA_W  result buffer read data
//   result_out        out DATA_W  captured result
//   result_valid      out 1       result_out strobe
//   busy              out 1       job in progress
//   done              out 1       one-cycle completion pulse
// Every output is a flop loaded from next-state values, so outputs belong to
// the state they are shown in. result_in is taken to reflect the read
// address presented in the same cycle; it is captured on the following edge,
// which puts the fourth strobe on the FINISH cycle.
// ---------------------------------------------------------------------------
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DRAIN_LEN = 4,
  parameter int LEN_2BY2  = 18,
  parameter int LEN_3BY3  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
`ifdef CONV_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              sys_en,
  output logic [4:0]        input_addr,
  output logic [4:0]        filter_addr,
  output logic [3:0]        buffer_we,
  output logic [1:0]        buffer_read_addr,
  input  logic [DATA_W-1:0] result_in,
  output logic [DATA_W-1:0] result_out,
  output logic              result_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [5:0] DRAIN_LAST = 6'(DRAIN_LEN - 1);
  localparam logic [5:0] READ_LAST  = 6'd3;

  state_t      state_r;
  state_t      state_nx;
  logic [5:0]  cnt_r;
  logic [5:0]  cnt_nx;
  logic [1:0]  mode_r;
  logic [1:0]  mode_nx;
  logic [5:0]  last_k_s;

  logic        sys_en_r;
  logic [4:0]  input_addr_r;
  logic [4:0]  filter_addr_r;
  logic [3:0]  buffer_we_r;
  logic [1:0]  buffer_read_addr_r;
  logic [DATA_W-1:0] result_out_r;
  logic        result_valid_r;
  logic        busy_r;
  logic        done_r;

  logic [4:0]  ag_input_addr_s;
  logic [4:0]  ag_filter_addr_s;
  logic [3:0]  ag_buffer_we_s;

  // Last COMPUTE count for the latched mode.
  always_comb begin
    case (mode_r)
      MODE_SINGLE: last_k_s = SINGLE_LAST_K;
      MODE_2BY2:   last_k_s = 6'(LEN_2BY2 - 1);
      MODE_3BY3:   last_k_s = 6'(LEN_3BY3 - 1);
      default:     last_k_s = 6'd0;
    endcase
  end

  // Next-state logic; one shared counter is reused as k, drain and read index.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    mode_nx  = mode_r;
    case (state_r)
      IDLE: begin
        if (start && (mode != MODE_RSVD)) begin
          state_nx = COMPUTE;
          cnt_nx   = 6'd0;
          mode_nx  = mode;
        end else begin
          state_nx = IDLE;
          cnt_nx   = 6'd0;
        end
      end
      COMPUTE: begin
        if (cnt_r == last_k_s) begin
          state_nx = DRAIN;
          cnt_nx   = 6'd0;
        end else begin
          cnt_nx   = cnt_r + 6'd1;
        end
      end
      DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_nx = READ;
          cnt_nx   = 6'd0;
        end else begin
          cnt_nx   = cnt_r + 6'd1;
        end
      end
      READ: begin
        if (cnt_r == READ_LAST) begin
          state_nx = FINISH;
          cnt_nx   = 6'd0;
        end else begin
          cnt_nx   = cnt_r + 6'd1;
        end
      end
      FINISH: begin
        state_nx = IDLE;
        cnt_nx   = 6'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 6'd0;
      end
    endcase
`ifdef CONV_SEQ_ABORT_EN
    if (abort && (state_r != IDLE)) begin
      state_nx = IDLE;
      cnt_nx   = 6'd0;
    end else begin
      state_nx = state_nx;
    end
`endif
  end

  conv_addr_gen u_addr_gen (
    .active      (state_nx == COMPUTE),
    .mode        (mode_nx),
    .k           (cnt_nx),
    .input_addr  (ag_input_addr_s),
    .filter_addr (ag_filter_addr_s),
    .buffer_we   (ag_buffer_we_s)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= IDLE;
      cnt_r              <= 6'd0;
      mode_r             <= 2'd0;
      sys_en_r           <= 1'b0;
      input_addr_r       <= 5'd0;
      filter_addr_r      <= 5'd0;
      buffer_we_r        <= 4'b0000;
      buffer_read_addr_r <= 2'd0;
      result_out_r       <= '0;
      result_valid_r     <= 1'b0;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
    end else begin
      state_r            <= state_nx;
      cnt_r              <= cnt_nx;
      mode_r             <= mode_nx;
      sys_en_r           <= (state_nx == COMPUTE) || (state_nx == DRAIN);
      input_addr_r       <= ag_input_addr_s;
      filter_addr_r      <= ag_filter_addr_s;
      buffer_we_r        <= ag_buffer_we_s;
      buffer_read_addr_r <= (state_nx == READ) ? cnt_nx[1:0] : 2'd0;
      busy_r             <= (state_nx != IDLE);
      done_r             <= (state_nx == FINISH);
      // Capture the word for the address shown this cycle; an abort out of
      // READ lands in IDLE and so drops the strobe.
      if ((state_r == READ) && (state_nx != IDLE)) begin
        result_out_r   <= result_in;
        result_valid_r <= 1'b1;
      end else begin
        result_out_r   <= '0;
        result_valid_r <= 1'b0;
      end
    end
  end

  assign sys_en           = sys_en_r;
  assign input_addr       = input_addr_r;
  assign filter_addr      = filter_addr_r;
  assign buffer_we        = buffer_we_r;
  assign buffer_read_addr = buffer_read_addr_r;
  assign result_out       = result_out_r;
  assign result_valid     = result_valid_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_conv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_sequencer
// Bench for conv_sequencer. A job-level model predicts every output from the
// cycle index within a job; a compare process checks it on every falling
// edge. Directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_conv_sequencer;

  localparam int DATA_W    = 8;
  localparam int DRAIN_LEN = 4;
  localparam int LEN_2BY2  = 18;
  localparam int LEN_3BY3  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
`ifdef CONV_SEQ_ABORT_EN
  logic              abort;
`endif
  logic              sys_en;
  logic [4:0]        input_addr;
  logic [4:0]        filter_addr;
  logic [3:0]        buffer_we;
  logic [1:0]        buffer_read_addr;
  logic [DATA_W-1:0] result_in;
  logic [DATA_W-1:0] result_out;
  logic              result_valid;
  logic              busy;
  logic              done;

  logic [7:0] rmem [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  assign result_in = rmem[buffer_read_addr];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state: job active, cycle index within job (1 = first COMPUTE), mode
  bit m_active = 1'b0;
  int m_n      = 0;
  int m_mode   = 0;

  logic [7:0] got_q [$];

  always #5 clk = ~clk;

  conv_sequencer #(
    .DATA_W(DATA_W), .DRAIN_LEN(DRAIN_LEN), .LEN_2BY2(LEN_2BY2), .LEN_3BY3(LEN_3BY3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef CONV_SEQ_ABORT_EN
    .abort(abort),
`endif
    .sys_en(sys_en), .input_addr(input_addr), .filter_addr(filter_addr),
    .buffer_we(buffer_we), .buffer_read_addr(buffer_read_addr),
    .result_in(result_in), .result_out(result_out), .result_valid(result_valid),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int job_len(input int md);
    return ((md == 0) ? 36 : (md == 1) ? LEN_2BY2 : LEN_3BY3) + DRAIN_LEN + 5;
  endfunction

  // What every output must be at job cycle n, straight from the job timeline.
  function automatic void model_out(input bit act, input int md, input int n,
      output int e_sys, output int e_in, output int e_filt, output int e_we,
      output int e_rd, output int e_val, output int e_res, output int e_busy,
      output int e_done);
    int c, k, w, t;
    int base [4] = '{0, 1, 4, 5};
    e_sys = 0; e_in = 0; e_filt = 0; e_we = 0; e_rd = 0;
    e_val = 0; e_res = 0; e_busy = 0; e_done = 0;
    if (act) begin
      c = (md == 0) ? 36 : (md == 1) ? LEN_2BY2 : LEN_3BY3;
      e_busy = 1;
      if (n <= c + DRAIN_LEN) e_sys = 1;
      if (n <= c) begin
        k = n - 1;
        if (md == 0) begin
          w = k / 9;
          t = k % 9;
          e_in   = base[w] + (t / 3) * 4 + (t % 3);
          e_filt = t;
          e_we   = (t == 8) ? (1 << w) : 0;
        end else begin
          e_in   = k;
          e_filt = k;
        end
      end
      if (n >= c + DRAIN_LEN + 1 && n <= c + DRAIN_LEN + 4) e_rd = n - (c + DRAIN_LEN + 1);
      if (n >= c + DRAIN_LEN + 2 && n <= c + DRAIN_LEN + 5) begin
        e_val = 1;
        e_res = int'(rmem[n - (c + DRAIN_LEN + 2)]);
      end
      if (n == c + DRAIN_LEN + 5) e_done = 1;
    end
  endfunction

  // Job-level model update.
  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_n      <= 0;
`ifdef CONV_SEQ_ABORT_EN
    end else if (m_active && abort) begin
      m_active <= 1'b0;
      m_n      <= 0;
`endif
    end else if (m_active) begin
      if (m_n == job_len(m_mode)) begin
        m_active <= 1'b0;
        m_n      <= 0;
      end else begin
        m_n <= m_n + 1;
      end
    end else if (start && mode != 2'd3) begin
      m_active <= 1'b1;
      m_n      <= 1;
      m_mode   <= int'(mode);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int e_sys, e_in, e_filt, e_we, e_rd, e_val, e_res, e_busy, e_done;
    if (chk_en) begin
      model_out(m_active, m_mode, m_n, e_sys, e_in, e_filt, e_we, e_rd,
                e_val, e_res, e_busy, e_done);
      chk("sys_en", int'(sys_en), e_sys);
      chk("input_addr", int'(input_addr), e_in);
      chk("filter_addr", int'(filter_addr), e_filt);
      chk("buffer_we", int'(buffer_we), e_we);
      chk("buffer_read_addr", int'(buffer_read_addr), e_rd);
      chk("result_valid", int'(result_valid), e_val);
      if (e_val == 1) chk("result_out", int'(result_out), e_res);
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
    end
  end

  // Collect strobed results.
  always @(negedge clk) begin
    if (result_valid) got_q.push_back(result_out);
  end

  // Launch a job and count cycles to done, sys_en cycles and write strobes.
  // poke adds start attempts (including reserved mode) while busy.
  task automatic run_job(input int md, input bit poke,
                         output int cyc, output int sys_cnt, output int we_cnt);
    cyc = -1; sys_cnt = 0; we_cnt = 0;
    got_q.delete();
    start = 1'b1;
    mode  = 2'(md);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && i == 5) begin start = 1'b1; mode = 2'd2; end
      if (poke && i == 6) begin start = 1'b1; mode = 2'd3; end
      if (sys_en) sys_cnt++;
      if (buffer_we != 4'b0000) we_cnt++;
      if (done) begin
        cyc = i;
        break;
      end
    end
    start = 1'b0;
    mode  = 2'(md);
    if (cyc < 0) chk("job_done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic chk_results(input string name);
    chk({name, "_count"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk({name, "_word"}, (i < got_q.size()) ? int'(got_q[i]) : -1, int'(rmem[i]));
  endtask

  initial begin
    int cyc, sc, wc;
    int e_sys, e_in, e_filt, e_we, e_rd, e_val, e_res, e_busy, e_done;
    int exp_addr [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    rst = 1'b1; start = 1'b0; mode = 2'd0;
`ifdef CONV_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_sys_en", int'(sys_en), 0);
    chk("reset_result_valid", int'(result_valid), 0);
    chk("reset_result_out", int'(result_out), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;

    // pin the model against hand-computed values
    for (int n = 1; n <= 9; n++) begin
      model_out(1'b1, 0, n, e_sys, e_in, e_filt, e_we, e_rd, e_val, e_res, e_busy, e_done);
      chk("model_single_addr", e_in, exp_addr[n-1]);
    end
    model_out(1'b1, 0, 9, e_sys, e_in, e_filt, e_we, e_rd, e_val, e_res, e_busy, e_done);
    chk("model_we_c9", e_we, 1);
    model_out(1'b1, 0, 36, e_sys, e_in, e_filt, e_we, e_rd, e_val, e_res, e_busy, e_done);
    chk("model_we_c36", e_we, 8);
    model_out(1'b1, 0, 45, e_sys, e_in, e_filt, e_we, e_rd, e_val, e_res, e_busy, e_done);
    chk("model_done_c45", e_done, 1);

    // single job with start attempts while busy
    run_job(0, 1'b1, cyc, sc, wc);
    chk("single_done_cycle", cyc, 45);
    chk("single_sys_en_cycles", sc, 40);
    chk("single_we_strobes", wc, 4);
    chk_results("single_result");

    // 3by3 job
    run_job(2, 1'b0, cyc, sc, wc);
    chk("3by3_done_cycle", cyc, 21);
    chk("3by3_sys_en_cycles", sc, 16);
    chk("3by3_we_strobes", wc, 0);
    chk_results("3by3_result");

    // 2by2 job
    run_job(1, 1'b0, cyc, sc, wc);
    chk("2by2_done_cycle", cyc, 27);
    chk("2by2_sys_en_cycles", sc, 22);

    // reserved mode in IDLE is ignored
    start = 1'b1; mode = 2'd3;
    @(negedge clk);
    start = 1'b0; mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mode3_busy", int'(busy), 0);
      chk("mode3_done", int'(done), 0);
    end

    // reset at k = 20 in single mode, with start asserted alongside it
    start = 1'b1; mode = 2'd0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("k20_input_addr", int'(input_addr), 6);
    chk("k20_filter_addr", int'(filter_addr), 2);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sys_en", int'(sys_en), 0);
    chk("midrst_input_addr", int'(input_addr), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored_busy", int'(busy), 0);
    run_job(0, 1'b0, cyc, sc, wc);
    chk("after_rst_done_cycle", cyc, 45);
    chk_results("after_rst_result");

`ifdef CONV_SEQ_ABORT_EN
    // abort during READ of a 3by3 job
    start = 1'b1; mode = 2'd2;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_abort_valid", int'(result_valid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", int'(result_valid), 0);
    chk("abort_busy", int'(busy), 0);
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) sc++;
    end
    chk("abort_no_done", sc, 0);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
